// File: rtl/c64_dma_pkg.sv
// Shared types and defaults for the C64 expansion-port DMA responder.
package c64_dma_pkg;

  localparam int SETTLE_CYCLES_DEF = 3;
  localparam int HOLD_CYCLES_DEF   = 2;
  localparam int CNT_W             = 4;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SETTLE   = 3'd1,
    ST_READY    = 3'd2,
    ST_CYC_PHI1 = 3'd3,
    ST_CYC_PHI2 = 3'd4,
    ST_HOLD     = 3'd5
  } dma_state_e;

  // rise marks the start of phi2, fall marks the start of phi1.
  typedef struct packed {
    logic rise;
    logic fall;
  } phi2_tick_t;

endpackage

// File: rtl/phi2_counter.sv
// Down-counter stepped once per phi2 period; shared by the settle and hold waits.
module phi2_counter
  import c64_dma_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             expire
);

  logic [CNT_W-1:0] count_q, count_d;

  // NOTE: every output of this block gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    count_d = count_q;
    expire  = 1'b0;
    if (load) begin
      count_d = load_val;
    end else if (dec) begin
      // expire on the tick that takes the count to zero (or finds it already there)
      expire  = (count_q <= CNT_W'(1));
      count_d = (count_q == '0) ? '0 : count_q - CNT_W'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

endmodule

// File: rtl/c64_dma_port.sv
// C64-side responder for the REU toggle handshake: owns /DMA and runs one
// 6510-timed bus cycle per request toggle, then toggles dma_ack.
module c64_dma_port
  import c64_dma_pkg::*;
#(
  parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEF,
  parameter int HOLD_CYCLES   = HOLD_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] dma_a,
  input  logic [7:0]  dma_d,
  input  logic        dma_rw,
  input  logic        dma_req,
  output logic        dma_ack,
  output logic [7:0]  dma_q,
  input  logic        phi2_rise,
  input  logic        phi2_fall,
  input  logic        ba,
  input  logic [7:0]  bus_d_in,
  output logic        dma_n,
  output logic [15:0] bus_a,
  output logic        bus_a_oe,
  output logic        bus_rw_n,
  output logic [7:0]  bus_d,
  output logic        bus_d_oe
);

  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES);
  localparam logic [CNT_W-1:0] HOLD_LOAD   = CNT_W'(HOLD_CYCLES);

  dma_state_e state_q, state_d;
  phi2_tick_t tick;

  logic        dma_n_q,    dma_n_d;
  logic [15:0] bus_a_q,    bus_a_d;
  logic        bus_a_oe_q, bus_a_oe_d;
  logic        bus_rw_n_q, bus_rw_n_d;
  logic [7:0]  bus_d_q,    bus_d_d;
  logic        bus_d_oe_q, bus_d_oe_d;
  logic [7:0]  dma_q_q,    dma_q_d;
  logic        dma_ack_q,  dma_ack_d;

  logic             pending;
  logic             start_cycle;
  logic             cnt_load;
  logic [CNT_W-1:0] cnt_load_val;
  logic             cnt_dec;
  logic             cnt_expire;

  assign tick    = '{rise: phi2_rise, fall: phi2_fall};
  assign pending = (dma_req != dma_ack_q);

  phi2_counter u_wait_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .dec      (cnt_dec),
    .expire   (cnt_expire)
  );

  always_comb begin
    state_d      = state_q;
    dma_n_d      = dma_n_q;
    bus_a_d      = bus_a_q;
    bus_a_oe_d   = bus_a_oe_q;
    bus_rw_n_d   = bus_rw_n_q;
    bus_d_d      = bus_d_q;
    bus_d_oe_d   = bus_d_oe_q;
    dma_q_d      = dma_q_q;
    dma_ack_d    = dma_ack_q;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    cnt_dec      = 1'b0;
    start_cycle  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        dma_n_d    = 1'b1;
        bus_a_oe_d = 1'b0;
        if (pending) begin
          dma_n_d      = 1'b0;
          cnt_load     = 1'b1;
          cnt_load_val = SETTLE_LOAD;
          state_d      = ST_SETTLE;
        end
      end

      // Let pending CPU writes drain before taking the bus.
      ST_SETTLE: begin
        cnt_dec = tick.fall;
        if (cnt_expire) state_d = ST_READY;
      end

      ST_READY: begin
        if (tick.fall) begin
          if (pending && ba) begin
            start_cycle = 1'b1;
          end else if (ba) begin
            cnt_load     = 1'b1;
            cnt_load_val = HOLD_LOAD;
            state_d      = ST_HOLD;
          end
        end
      end

      ST_CYC_PHI1: begin
        if (tick.rise) begin
          bus_d_oe_d = ~bus_rw_n_q;
          state_d    = ST_CYC_PHI2;
        end
      end

      // R/W returns to read so the still-driven address cannot cause a second write.
      ST_CYC_PHI2: begin
        if (tick.fall) begin
          if (bus_rw_n_q) dma_q_d = bus_d_in;
          dma_ack_d  = ~dma_ack_q;
          bus_d_oe_d = 1'b0;
          bus_rw_n_d = 1'b1;
          state_d    = ST_READY;
        end
      end

      ST_HOLD: begin
        if (tick.fall) begin
          if (pending && ba) begin
            start_cycle = 1'b1;
          end else if (!pending) begin
            cnt_dec = 1'b1;
            if (cnt_expire) begin
              bus_a_oe_d = 1'b0;
              dma_n_d    = 1'b1;
              state_d    = ST_IDLE;
            end
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // Operands are captured once here; later changes on dma_a/dma_rw are ignored.
    if (start_cycle) begin
      bus_a_d    = dma_a;
      bus_rw_n_d = ~dma_rw;
      bus_d_d    = dma_d;
      bus_a_oe_d = 1'b1;
      state_d    = ST_CYC_PHI1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      dma_n_q    <= 1'b1;
      bus_a_q    <= '0;
      bus_a_oe_q <= 1'b0;
      bus_rw_n_q <= 1'b1;
      bus_d_q    <= '0;
      bus_d_oe_q <= 1'b0;
      dma_q_q    <= '0;
    end else begin
      state_q    <= state_d;
      dma_n_q    <= dma_n_d;
      bus_a_q    <= bus_a_d;
      bus_a_oe_q <= bus_a_oe_d;
      bus_rw_n_q <= bus_rw_n_d;
      bus_d_q    <= bus_d_d;
      bus_d_oe_q <= bus_d_oe_d;
      dma_q_q    <= dma_q_d;
    end
  end

  // NOTE: dma_ack is deliberately outside reset; it powers up 0 from device configuration and the initiator resyncs req to it.
  always_ff @(posedge clk) begin
    if (!reset) dma_ack_q <= dma_ack_d;
  end

  assign dma_ack  = dma_ack_q;
  assign dma_q    = dma_q_q;
  assign dma_n    = dma_n_q;
  assign bus_a    = bus_a_q;
  assign bus_a_oe = bus_a_oe_q;
  assign bus_rw_n = bus_rw_n_q;
  assign bus_d    = bus_d_q;
  assign bus_d_oe = bus_d_oe_q;

endmodule

// File: tb/tb_c64_dma_port.sv
// Scoreboard bench for c64_dma_port: C64 memory model on the pads, reference
// memory for expected read data, timing derived from settle/hold period counts.
module tb_c64_dma_port;

  localparam int SETTLE  = 3;
  localparam int HOLD    = 2;
  localparam int PHI_LEN = 8;

  typedef struct {
    logic [15:0] a;
    logic [7:0]  d;
    logic        rw;
    logic [7:0]  exp_q;
  } txn_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] dma_a = '0;
  logic [7:0]  dma_d = '0;
  logic        dma_rw = 1'b0;
  logic        dma_req = 1'b0;
  logic        dma_ack;
  logic [7:0]  dma_q;
  logic        phi2_rise = 1'b0;
  logic        phi2_fall = 1'b0;
  logic        ba = 1'b1;
  logic [7:0]  bus_d_in;
  logic        dma_n;
  logic [15:0] bus_a;
  logic        bus_a_oe;
  logic        bus_rw_n;
  logic [7:0]  bus_d;
  logic        bus_d_oe;

  logic [7:0] c64_mem [65536];
  logic [7:0] ref_mem [65536];
  txn_t       sb[$];

  int n_checks = 0;
  int n_fail   = 0;
  int fall_cnt = 0;
  int mark_fall = 0;
  int dma_n_rises = 0;

  c64_dma_port #(.SETTLE_CYCLES(SETTLE), .HOLD_CYCLES(HOLD)) dut (
    .clk(clk), .reset(reset), .dma_a(dma_a), .dma_d(dma_d), .dma_rw(dma_rw),
    .dma_req(dma_req), .dma_ack(dma_ack), .dma_q(dma_q),
    .phi2_rise(phi2_rise), .phi2_fall(phi2_fall), .ba(ba), .bus_d_in(bus_d_in),
    .dma_n(dma_n), .bus_a(bus_a), .bus_a_oe(bus_a_oe), .bus_rw_n(bus_rw_n),
    .bus_d(bus_d), .bus_d_oe(bus_d_oe)
  );

  assign bus_d_in = c64_mem[bus_a];

  always #5 clk = ~clk;

  // phi2 tick generator: one-clk pulses, rise and fall never together.
  initial begin
    int ph = 0;
    forever begin
      @(negedge clk);
      phi2_fall = (ph == 0);
      phi2_rise = (ph == PHI_LEN / 2);
      ph = (ph + 1) % PHI_LEN;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pad-side memory model plus scoreboard pop on every ack toggle.
  initial begin
    txn_t t;
    logic        p_ack = 1'b0, p_dma_n = 1'b1, p_rw_n = 1'b1, p_d_oe = 1'b0;
    logic [15:0] p_a = '0;
    logic [7:0]  p_d = '0;
    forever begin
      @(posedge clk); #1;
      if (phi2_fall) begin
        fall_cnt++;
        if (p_d_oe && !p_rw_n) c64_mem[p_a] = p_d;
      end
      if (dma_ack !== p_ack) begin
        if (sb.size() == 0) begin
          check("spurious_ack", dma_ack, p_ack);
        end else begin
          t = sb.pop_front();
          check("ack_on_phi2_fall", phi2_fall, 1);
          check("cyc_addr", p_a, t.a);
          check("cyc_rw_n", p_rw_n, !t.rw);
          if (t.rw) begin
            check("wr_d_oe", p_d_oe, 1);
            check("wr_pad_data", p_d, t.d);
            check("wr_mem", c64_mem[t.a], t.d);
          end else begin
            check("rd_data", dma_q, t.exp_q);
          end
        end
      end
      if (bus_d_oe && !p_d_oe) check("d_oe_rises_on_phi2_rise", phi2_rise, 1);
      if (bus_d_oe) check("d_oe_only_in_write", {bus_a_oe, bus_rw_n}, 2'b10);
      if (dma_n) check("oes_off_while_dma_n_high", {bus_a_oe, bus_d_oe}, 2'b00);
      if (dma_n && !p_dma_n) dma_n_rises++;
      p_ack = dma_ack; p_dma_n = dma_n; p_a = bus_a; p_d = bus_d;
      p_rw_n = bus_rw_n; p_d_oe = bus_d_oe;
    end
  end

  // Return at a point where the next posedge carries no phi2_fall.
  task automatic wait_safe();
    do begin @(negedge clk); #1; end while (phi2_fall);
  endtask

  task automatic wait_falls(input int k);
    for (int i = 0; i < k; i++) begin
      do begin @(posedge clk); #2; end while (!phi2_fall);
    end
  endtask

  task automatic issue(input logic [15:0] a, input logic [7:0] d, input logic rw);
    txn_t t;
    wait_safe();
    t.a = a; t.d = d; t.rw = rw; t.exp_q = ref_mem[a];
    if (rw) ref_mem[a] = d;
    sb.push_back(t);
    dma_a = a; dma_d = d; dma_rw = rw;
    dma_req = ~dma_req;
    mark_fall = fall_cnt;
  endtask

  task automatic wait_ack(output int falls);
    int n = 0;
    do begin @(posedge clk); #2; n++; end while (dma_ack !== dma_req && n < 2000);
    if (n >= 2000) check("ack_timeout", dma_ack, dma_req);
    falls = fall_cnt - mark_fall;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (dma_n !== 1'b1 && n < 2000) begin @(posedge clk); #2; n++; end
    if (n >= 2000) check("idle_timeout", dma_n, 1);
  endtask

  initial begin
    int f, rises0;
    logic ack_save;
    logic [7:0]  old_v;
    logic [15:0] a;

    for (int i = 0; i < 65536; i++) begin
      c64_mem[i] = 8'($urandom);
      ref_mem[i] = c64_mem[i];
    end
    c64_mem[16'hD020] = 8'h0E;
    ref_mem[16'hD020] = 8'h0E;

    // Reset: outputs at reset values, a pending request is ignored.
    repeat (2) @(negedge clk);
    dma_req = dma_ack;
    @(posedge clk); #2;
    check("rst_dma_n", dma_n, 1);
    check("rst_oes", {bus_a_oe, bus_d_oe}, 2'b00);
    check("rst_rw_n", bus_rw_n, 1);
    check("rst_bus_a", bus_a, 0);
    check("rst_bus_d", bus_d, 0);
    check("rst_dma_q", dma_q, 0);
    @(negedge clk); dma_req = ~dma_ack;
    repeat (4) @(posedge clk); #2;
    check("rst_ignores_pending", dma_n, 1);
    @(negedge clk); dma_req = dma_ack; reset = 1'b0;

    // Single read of $D020: settle, one cycle, then hold release.
    issue(16'hD020, 8'h00, 1'b0);
    wait_ack(f);
    check("rd_latency_falls", f, SETTLE + 2);
    wait_falls(HOLD);
    check("rd_hold_dma_n_low", dma_n, 0);
    wait_falls(1);
    check("rd_hold_release_dma_n", dma_n, 1);
    check("rd_hold_release_a_oe", bus_a_oe, 0);

    // Single write of $41 to $0400.
    issue(16'h0400, 8'h41, 1'b1);
    wait_ack(f);
    check("wr_latency_falls", f, SETTLE + 2);
    check("wr_rw_n_back_to_read", bus_rw_n, 1);
    wait_idle();

    // Burst of 4 back-to-back reads: one settle, dma_n never released.
    rises0 = dma_n_rises;
    for (int i = 0; i < 4; i++) begin
      issue(16'($urandom), 8'h00, 1'b0);
      wait_ack(f);
      check("burst_latency_falls", f, (i == 0) ? SETTLE + 2 : 2);
      check("burst_dma_n_low", dma_n, 0);
    end
    check("burst_no_dma_n_release", dma_n_rises, rises0);
    wait_idle();

    // ba low for 5 periods while pending: settle runs, cycle is held off.
    wait_safe(); ba = 1'b0;
    issue(16'hD012, 8'h00, 1'b0);
    wait_falls(5);
    check("ba_low_no_a_oe", bus_a_oe, 0);
    check("ba_low_still_pending", dma_ack ^ dma_req, 1);
    wait_safe(); ba = 1'b1; mark_fall = fall_cnt;
    wait_ack(f);
    check("ba_release_latency_falls", f, 2);
    wait_idle();

    // Request arrives in HOLD with one period left: no re-settle, hold reloads.
    issue(16'h1234, 8'h00, 1'b0);
    wait_ack(f);
    wait_falls(HOLD);
    check("hold_pre_dma_n_low", dma_n, 0);
    issue(16'h1235, 8'h00, 1'b0);
    wait_ack(f);
    check("hold_restart_falls", f, 2);
    wait_falls(HOLD);
    check("hold_reload_dma_n_low", dma_n, 0);
    wait_falls(1);
    check("hold_reload_release", dma_n, 1);

    // Reset during CYC_PHI2 of a write: cycle lost, ack untouched.
    old_v = ref_mem[16'h2000];
    issue(16'h2000, 8'hA5, 1'b1);
    begin
      int n = 0;
      while (bus_d_oe !== 1'b1 && n < 500) begin @(posedge clk); #2; n++; end
      check("reach_cyc_phi2", bus_d_oe, 1);
    end
    wait_safe();
    ack_save = dma_ack;
    reset = 1'b1;
    @(posedge clk); #2;
    check("midrst_dma_n", dma_n, 1);
    check("midrst_oes", {bus_a_oe, bus_d_oe}, 2'b00);
    check("midrst_ack_kept", dma_ack, ack_save);
    void'(sb.pop_back());
    ref_mem[16'h2000] = old_v;
    @(negedge clk); dma_req = dma_ack;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    wait_falls(3);
    check("postrst_idle_dma_n", dma_n, 1);
    check("postrst_ack_kept", dma_ack, ack_save);
    check("postrst_mem_untouched", c64_mem[16'h2000], old_v);

    // Random mix over a small window so reads hit earlier writes.
    for (int i = 0; i < 30; i++) begin
      repeat ($urandom_range(0, 60)) @(negedge clk);
      a = 16'hC000 | 16'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) begin
        wait_safe(); ba = 1'b0;
        issue(a, 8'($urandom), 1'($urandom));
        wait_falls($urandom_range(1, 6));
        wait_safe(); ba = 1'b1;
      end else begin
        issue(a, 8'($urandom), 1'($urandom));
      end
      wait_ack(f);
    end
    wait_idle();
    check("scoreboard_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
